// File: rtl/ttt_pkg.sv
// Shared encodings, state enum and board geometry for the tic-tac-toe move generator.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_COMP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIN,
    S_BLOCK,
    S_PICK,
    S_DONE
  } state_t;

  // 1-based cell index; 0 means "no cell"
  typedef logic [3:0] cell_idx_t;

  // Eight winning lines: rows, columns, then the two diagonals
  localparam cell_idx_t LINE [8][3] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9},
    '{4'd3, 4'd5, 4'd7}
  };

  localparam cell_idx_t CORNER [4] = '{4'd1, 4'd3, 4'd7, 4'd9};
  localparam cell_idx_t EDGE   [4] = '{4'd2, 4'd4, 4'd6, 4'd8};

endpackage

// File: rtl/ttt_line_eval.sv
// Checks one board line for "two of mark plus one empty" and reports the empty cell.
// Latency: combinational.
// Backpressure: none.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] c0,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  cell_idx_t  p0,
  input  cell_idx_t  p1,
  input  cell_idx_t  p2,
  input  logic [1:0] mark,
  output logic       hit,
  output cell_idx_t  empty_pos
);

  // At most one of the three patterns can match since only one cell may be empty
  always_comb begin
    hit       = 1'b0;
    empty_pos = '0;
    if (c0 == CELL_EMPTY && c1 == mark && c2 == mark) begin
      hit       = 1'b1;
      empty_pos = p0;
    end else if (c1 == CELL_EMPTY && c0 == mark && c2 == mark) begin
      hit       = 1'b1;
      empty_pos = p1;
    end else if (c2 == CELL_EMPTY && c0 == mark && c1 == mark) begin
      hit       = 1'b1;
      empty_pos = p2;
    end
  end

endmodule

// File: rtl/ttt_move_gen.sv
// Picks the computer's next move: win, block, centre, corner, edge, scanning one line per cycle.
// Latency: 1..17 cycles after the request edge (1..9 without the block scan).
// Backpressure: result held with valid until ack; requests while busy are dropped.
module ttt_move_gen
  import ttt_pkg::*;
#(
  parameter bit EN_BLOCK     = 1'b1,
  parameter bit CORNER_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        ack,
  input  logic [17:0] board,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  move_pos,
  output logic        no_move
);

  state_t      state_q;
  logic [17:0] snap_q;
  logic [2:0]  idx_q;
  logic        busy_q;
  logic        valid_q;
  cell_idx_t   pos_q;
  logic        no_move_q;

  // Cells indexed 1..9; unused slots read as occupied so they can never be chosen
  logic [1:0]  cells [16];
  logic [1:0]  mark;
  logic        line_hit;
  cell_idx_t   line_pos;
  cell_idx_t   pick_pos_d;
  logic        pick_none_d;

  // Unpack the snapshot into a cell-addressable array
  always_comb begin
    for (int i = 0; i < 16; i++) cells[i] = 2'b11;
    for (int i = 1; i <= 9; i++) cells[i] = snap_q[2*i-2 +: 2];
  end

  assign mark = (state_q == S_BLOCK) ? CELL_PLAYER : CELL_COMP;

  ttt_line_eval u_line_eval (
    .c0        (cells[LINE[idx_q][0]]),
    .c1        (cells[LINE[idx_q][1]]),
    .c2        (cells[LINE[idx_q][2]]),
    .p0        (LINE[idx_q][0]),
    .p1        (LINE[idx_q][1]),
    .p2        (LINE[idx_q][2]),
    .mark      (mark),
    .hit       (line_hit),
    .empty_pos (line_pos)
  );

  // Fallback choice: centre, then first empty cell of the preferred group, then the other group
  always_comb begin
    pick_pos_d  = '0;
    pick_none_d = 1'b1;
    if (cells[5] == CELL_EMPTY) begin
      pick_pos_d  = 4'd5;
      pick_none_d = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (pick_none_d && cells[CORNER_FIRST ? CORNER[i] : EDGE[i]] == CELL_EMPTY) begin
        pick_pos_d  = CORNER_FIRST ? CORNER[i] : EDGE[i];
        pick_none_d = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pick_none_d && cells[CORNER_FIRST ? EDGE[i] : CORNER[i]] == CELL_EMPTY) begin
        pick_pos_d  = CORNER_FIRST ? EDGE[i] : CORNER[i];
        pick_none_d = 1'b0;
      end
    end
  end

  // Search FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      pos_q     <= '0;
      no_move_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            snap_q  <= board;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WIN;
          end
        end
        S_WIN, S_BLOCK: begin
          if (line_hit) begin
            pos_q   <= line_pos;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else if (idx_q == 3'd7) begin
            idx_q   <= '0;
            state_q <= (state_q == S_WIN && EN_BLOCK) ? S_BLOCK : S_PICK;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        S_PICK: begin
          pos_q     <= pick_pos_d;
          no_move_q <= pick_none_d;
          valid_q   <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          if (ack) begin
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            pos_q     <= '0;
            no_move_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign move_pos = pos_q;
  assign no_move  = no_move_q;

endmodule

// File: tb/tb_ttt_move_gen.sv
// Scoreboard bench for ttt_move_gen: two instances (corner-first and edge-first) share stimulus.
// Latency: expected latency is carried in each scoreboard entry.
// Backpressure: ack is held off for a few cycles on selected vectors.
module tb_ttt_move_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        ack = 1'b0;
  logic [17:0] board = '0;

  logic       busy_a, valid_a, no_move_a;
  logic [3:0] move_pos_a;
  logic       busy_b, valid_b, no_move_b;
  logic [3:0] move_pos_b;

  typedef struct {
    int pos;
    int nm;
    int lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;

  ttt_move_gen #(.EN_BLOCK(1'b1), .CORNER_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .board(board),
    .busy(busy_a), .valid(valid_a), .move_pos(move_pos_a), .no_move(no_move_a)
  );

  ttt_move_gen #(.EN_BLOCK(1'b1), .CORNER_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .board(board),
    .busy(busy_b), .valid(valid_b), .move_pos(move_pos_b), .no_move(no_move_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Board literal: one char per cell 1..9; C computer, P player, X neutral, anything else empty
  function automatic logic [17:0] mk(input string s);
    logic [17:0] b;
    logic [1:0]  v;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      case (s[i])
        "C":     v = 2'b10;
        "P":     v = 2'b01;
        "X":     v = 2'b11;
        default: v = 2'b00;
      endcase
      b[2*i +: 2] = v;
    end
    return b;
  endfunction

  // Monitor for the corner-first instance
  always @(negedge clk) begin
    exp_t e;
    if (valid_a && !pv_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 1, 0);
      end else begin
        e = qa.pop_front();
        check("a_move_pos", int'(move_pos_a), e.pos);
        check("a_no_move", int'(no_move_a), e.nm);
        check("a_latency", cyc - start_cyc, e.lat);
      end
    end
    pv_a = valid_a;
  end

  // Monitor for the edge-first instance
  always @(negedge clk) begin
    exp_t e;
    if (valid_b && !pv_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 1, 0);
      end else begin
        e = qb.pop_front();
        check("b_move_pos", int'(move_pos_b), e.pos);
        check("b_no_move", int'(no_move_b), e.nm);
        check("b_latency", cyc - start_cyc, e.lat);
      end
    end
    pv_b = valid_b;
  end

  // One request: push expectations, wait for valid, optionally stall ack, then release
  task automatic run_vec(input string s, input int pa, input int pb, input int nm,
                         input int lat, input int hold, input bit both, input bit poke);
    @(negedge clk);
    board = mk(s);
    req = 1'b1;
    start_cyc = cyc + 1;
    qa.push_back('{pa, nm, lat});
    qb.push_back('{pb, nm, lat});
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", int'(busy_a), 1);
    for (int i = 0; i < 40 && !valid_a; i++) begin
      if (poke && i == 2) begin
        board = mk("CC.......");
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0;
    if (!valid_a) begin
      check("valid_timeout", 0, 1);
      qa.delete();
      qb.delete();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", int'(valid_a), 1);
      check("hold_pos_a", int'(move_pos_a), pa);
      check("hold_pos_b", int'(move_pos_b), pb);
      check("hold_no_move", int'(no_move_a), nm);
    end
    ack = 1'b1;
    if (both) req = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    req = 1'b0;
    check("ack_valid", int'(valid_a), 0);
    check("ack_busy", int'(busy_a), 0);
    check("ack_pos", int'(move_pos_a), 0);
    check("ack_no_move", int'(no_move_b), 0);
    if (both) begin
      @(negedge clk);
      check("req_with_ack_ignored", int'(busy_a), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_pos", int'(move_pos_a), 0);
    check("rst_no_move", int'(no_move_a), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy_b", int'(busy_b), 0);

    //       board        a  b  nm lat hold both poke
    run_vec(".........", 5, 5, 0, 17, 0, 0, 0);
    run_vec("CC.PP....", 3, 3, 0, 1,  0, 0, 0);
    run_vec("C.....PP.", 9, 9, 0, 11, 0, 0, 0);
    run_vec("....P....", 1, 2, 0, 17, 0, 0, 0);
    run_vec("CPCCPPPCP", 0, 0, 1, 17, 5, 1, 0);
    run_vec("..C.C....", 7, 7, 0, 8,  0, 0, 0);
    run_vec("..P.P....", 7, 7, 0, 16, 0, 0, 0);
    run_vec("CC....CC.", 3, 3, 0, 1,  0, 0, 0);
    run_vec("X...X....", 3, 2, 0, 17, 2, 0, 0);

    // Abort a scan in BLOCK at line 3 with an asynchronous reset
    @(negedge clk);
    board = mk(".........");
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_abort_busy", int'(busy_a), 1);
    check("pre_abort_valid", int'(valid_a), 0);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy_a), 0);
    check("abort_valid", int'(valid_a), 0);
    check("abort_pos", int'(move_pos_a), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh search after reset; a mid-scan req with a winning board must be ignored
    run_vec(".........", 5, 5, 0, 17, 0, 0, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", qa.size() + qb.size(), 0);
    check("final_idle", int'(busy_a) + int'(busy_b) + int'(valid_a) + int'(valid_b), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
